// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings for the two-master arbiter: transfer types,
// data-phase owner and the captured address-phase record.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } aphase_t;

endpackage

// File: rtl/ahbl_arb2_pend.sv
// One-entry holding buffer for an address phase that the master believes
// was accepted but that could not yet be forwarded to the slave.
module ahbl_arb2_pend
    import ahbl_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    capture,
    input  logic    clear,
    input  aphase_t live,
    output logic    valid,
    output aphase_t held
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            held  <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            held  <= live;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ahbl_arb2.sv
// Two-master AHB-Lite arbiter in front of a single slave. Losing or stalled
// address phases are parked in a per-master buffer and replayed later.
module ahbl_arb2
    import ahbl_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic        S_HWRITE,
    output logic [2:0]  S_HSIZE,
    output logic [31:0] S_HWDATA,
    output logic        S_HREADY,
    input  logic        S_HREADYOUT,
    input  logic [31:0] S_HRDATA,
    output logic [1:0]  dbg_owner
);

    owner_t     owner;
    owner_t     last_grant;
    logic       s_ready;
    logic [1:0] m_ready;
    logic [1:0] live;
    logic [1:0] req;
    logic [1:0] win;
    logic [1:0] pend_valid;
    logic [1:0] capture;
    logic [1:0] clear;
    aphase_t    live_ap [2];
    aphase_t    pend_ap [2];
    aphase_t    win_ap;

    assign s_ready = (owner == OWN_NONE) ? 1'b1 : S_HREADYOUT;

    // A master with a parked beat is held off unless it owns the data phase.
    assign m_ready[0] = (owner == OWN_M0) ? S_HREADYOUT : !pend_valid[0];
    assign m_ready[1] = (owner == OWN_M1) ? S_HREADYOUT : !pend_valid[1];

    assign live[0] = ((M0_HTRANS == HTRANS_NONSEQ) || (M0_HTRANS == HTRANS_SEQ)) && m_ready[0];
    assign live[1] = ((M1_HTRANS == HTRANS_NONSEQ) || (M1_HTRANS == HTRANS_SEQ)) && m_ready[1];
    assign req     = pend_valid | live;

    assign live_ap[0] = '{addr: M0_HADDR, write: M0_HWRITE, size: M0_HSIZE};
    assign live_ap[1] = '{addr: M1_HADDR, write: M1_HWRITE, size: M1_HSIZE};

    // Pending beats outrank live ones; a tie falls to priority or round-robin.
    always_comb begin
        win = 2'b00;
        if (HRESETn && s_ready) begin
            if (req == 2'b11) begin
                if (pend_valid[0] != pend_valid[1]) begin
                    win = pend_valid[0] ? 2'b01 : 2'b10;
                end else if (RR_EN && (last_grant == OWN_M0)) begin
                    win = 2'b10;
                end else begin
                    win = 2'b01;
                end
            end else begin
                win = req;
            end
        end
    end

    always_comb begin
        win_ap = '0;
        if (win[0]) begin
            win_ap = pend_valid[0] ? pend_ap[0] : live_ap[0];
        end else if (win[1]) begin
            win_ap = pend_valid[1] ? pend_ap[1] : live_ap[1];
        end
    end

    // Pending and live beats of one master never coexist, so a losing live
    // beat always finds its buffer empty.
    assign capture = live & ~win;
    assign clear   = win & pend_valid;

    ahbl_arb2_pend u_pend0 (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .capture (capture[0]),
        .clear   (clear[0]),
        .live    (live_ap[0]),
        .valid   (pend_valid[0]),
        .held    (pend_ap[0])
    );

    ahbl_arb2_pend u_pend1 (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .capture (capture[1]),
        .clear   (clear[1]),
        .live    (live_ap[1]),
        .valid   (pend_valid[1]),
        .held    (pend_ap[1])
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner      <= OWN_NONE;
            last_grant <= OWN_M1;
        end else begin
            if (s_ready) begin
                owner <= win[0] ? OWN_M0 : (win[1] ? OWN_M1 : OWN_NONE);
            end
            if (|win) begin
                last_grant <= win[0] ? OWN_M0 : OWN_M1;
            end
        end
    end

    always_comb begin
        case (owner)
            OWN_M0:  S_HWDATA = M0_HWDATA;
            OWN_M1:  S_HWDATA = M1_HWDATA;
            default: S_HWDATA = '0;
        endcase
    end

    assign S_HADDR   = win_ap.addr;
    assign S_HWRITE  = win_ap.write;
    assign S_HSIZE   = win_ap.size;
    assign S_HTRANS  = (|win) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign S_HREADY  = s_ready;
    assign M0_HREADY = m_ready[0];
    assign M1_HREADY = m_ready[1];
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;
    assign dbg_owner = owner;

endmodule

// File: tb/tb_ahbl_arb2.sv
// Bench for ahbl_arb2: both RR_EN variants are instantiated on shared inputs
// and 'mode' selects which one drives the observed outputs.
module tb_ahbl_arb2;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, S_HRDATA;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HWRITE, M1_HWRITE, S_HREADYOUT;
    logic [2:0]  M0_HSIZE, M1_HSIZE;

    logic [31:0] s_haddr_v [2];
    logic [31:0] s_hwdata_v [2];
    logic [31:0] m0_hrdata_v [2];
    logic [31:0] m1_hrdata_v [2];
    logic [1:0]  s_htrans_v [2];
    logic [1:0]  owner_v [2];
    logic [2:0]  s_hsize_v [2];
    logic        s_hwrite_v [2];
    logic        s_hready_v [2];
    logic        m0_hready_v [2];
    logic        m1_hready_v [2];

    logic mode = 1'b0;
    int   tests = 0;
    int   fails = 0;

    // Slave model state: the address phase it accepted at the last edge.
    logic        sl_dp_valid = 1'b0;
    logic        sl_dp_write = 1'b0;
    logic [31:0] sl_dp_addr = '0;

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahbl_arb2 #(.RR_EN(g == 1)) u_dut (
            .HCLK(HCLK), .HRESETn(HRESETn),
            .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
            .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA),
            .M0_HREADY(m0_hready_v[g]), .M0_HRDATA(m0_hrdata_v[g]),
            .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
            .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA),
            .M1_HREADY(m1_hready_v[g]), .M1_HRDATA(m1_hrdata_v[g]),
            .S_HADDR(s_haddr_v[g]), .S_HTRANS(s_htrans_v[g]), .S_HWRITE(s_hwrite_v[g]),
            .S_HSIZE(s_hsize_v[g]), .S_HWDATA(s_hwdata_v[g]), .S_HREADY(s_hready_v[g]),
            .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .dbg_owner(owner_v[g])
        );
    end

    wire [31:0] s_haddr   = s_haddr_v[mode];
    wire [31:0] s_hwdata  = s_hwdata_v[mode];
    wire [31:0] m0_hrdata = m0_hrdata_v[mode];
    wire [31:0] m1_hrdata = m1_hrdata_v[mode];
    wire [1:0]  s_htrans  = s_htrans_v[mode];
    wire [1:0]  owner     = owner_v[mode];
    wire        s_hwrite  = s_hwrite_v[mode];
    wire        s_hready  = s_hready_v[mode];
    wire        m0_hready = m0_hready_v[mode];
    wire        m1_hready = m1_hready_v[mode];

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {16'hC0DE, a[17:2]};
    endfunction

    function automatic logic [31:0] wd(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic idle_masters();
        M0_HTRANS = 2'b00; M0_HADDR = '0; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2; M0_HWDATA = '0;
        M1_HTRANS = 2'b00; M1_HADDR = '0; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2; M1_HWDATA = '0;
    endtask

    // Advance one clock; the slave model latches the phase visible before the edge.
    task automatic next_cycle();
        if (s_hready) begin
            sl_dp_valid = s_htrans[1];
            sl_dp_addr  = s_haddr;
            sl_dp_write = s_hwrite;
        end
        @(negedge HCLK);
        S_HRDATA = (sl_dp_valid && !sl_dp_write) ? rom(sl_dp_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        idle_masters();
        S_HREADYOUT = 1'b1;
        S_HRDATA = 32'hDEAD_BEEF;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        sl_dp_valid = 1'b0;
    endtask

    task automatic test_reset();
        mode = 1'b0;
        HRESETn = 1'b0;
        idle_masters();
        S_HREADYOUT = 1'b1;
        M0_HTRANS = 2'b10; M0_HADDR = 32'h40;
        #1;
        tests++; if (s_htrans !== 2'b00) begin fails++; $display("FAIL rst_htrans got %0h exp 0", s_htrans); end
        tests++; if (s_hready !== 1'b1) begin fails++; $display("FAIL rst_s_hready got %0b exp 1", s_hready); end
        tests++; if ({m0_hready, m1_hready} !== 2'b11) begin fails++; $display("FAIL rst_m_hready got %b exp 11", {m0_hready, m1_hready}); end
        tests++; if (owner !== 2'b00) begin fails++; $display("FAIL rst_owner got %0d exp 0", owner); end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if (s_htrans !== 2'b00) begin fails++; $display("FAIL idle_htrans c%0d got %0h exp 0", i, s_htrans); end
            tests++; if ({m0_hready, m1_hready} !== 2'b11) begin fails++; $display("FAIL idle_hready c%0d got %b exp 11", i, {m0_hready, m1_hready}); end
            next_cycle();
        end
    endtask

    task automatic test_single_read();
        mode = 1'b0;
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h0000_0010;
        #1;
        tests++; if (s_haddr !== 32'h10 || s_htrans !== 2'b10) begin fails++; $display("FAIL single_addr got %h/%0h exp 10/2", s_haddr, s_htrans); end
        tests++; if (m0_hready !== 1'b1) begin fails++; $display("FAIL single_nowait got %0b exp 1", m0_hready); end
        next_cycle();
        idle_masters();
        #1;
        tests++; if (m0_hready !== 1'b1 || m0_hrdata !== 32'hC0DE_0004) begin fails++; $display("FAIL single_data got %0b/%h exp 1/c0de0004", m0_hready, m0_hrdata); end
        next_cycle();
    endtask

    task automatic test_fixed_prio();
        mode = 1'b0;
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h0;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h4;
        #1;
        tests++; if (s_haddr !== 32'h0 || s_htrans !== 2'b10) begin fails++; $display("FAIL fp_n_addr got %h/%0h exp 0/2", s_haddr, s_htrans); end
        next_cycle();
        idle_masters();
        #1;
        tests++; if (s_haddr !== 32'h4 || s_htrans !== 2'b10) begin fails++; $display("FAIL fp_n1_addr got %h/%0h exp 4/2", s_haddr, s_htrans); end
        tests++; if (m1_hready !== 1'b0) begin fails++; $display("FAIL fp_n1_m1wait got %0b exp 0", m1_hready); end
        tests++; if (m0_hready !== 1'b1 || m0_hrdata !== 32'hC0DE_0000) begin fails++; $display("FAIL fp_n1_m0data got %0b/%h exp 1/c0de0000", m0_hready, m0_hrdata); end
        next_cycle();
        #1;
        tests++; if (m1_hready !== 1'b1 || m1_hrdata !== 32'hC0DE_0001) begin fails++; $display("FAIL fp_n2_m1data got %0b/%h exp 1/c0de0001", m1_hready, m1_hrdata); end
        tests++; if (s_htrans !== 2'b00) begin fails++; $display("FAIL fp_n2_idle got %0h exp 0", s_htrans); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        int k [2];
        int done [2];
        int fwd;
        int cyc;
        mode = 1'b1;
        do_reset();
        k[0] = 0; k[1] = 0; done[0] = 0; done[1] = 0; fwd = 0; cyc = 0;
        while (fwd < 8 && cyc < 40) begin
            M0_HTRANS = 2'b10; M0_HADDR = 32'h0000_0000 | (k[0] << 2);
            M1_HTRANS = 2'b10; M1_HADDR = 32'h0000_1000 | (k[1] << 2);
            #1;
            if (s_hready && s_htrans[1]) begin
                tests++;
                if (s_haddr[12] !== fwd[0]) begin fails++; $display("FAIL rr_grant n%0d got M%0d exp M%0d", fwd, s_haddr[12], fwd[0]); end
                done[s_haddr[12]]++;
                fwd++;
            end
            if (m0_hready) k[0]++;
            if (m1_hready) k[1]++;
            next_cycle();
            cyc++;
        end
        idle_masters();
        tests++; if (fwd !== 8) begin fails++; $display("FAIL rr_timeout got %0d exp 8 transfers", fwd); end
        tests++; if (done[0] !== 4 || done[1] !== 4) begin fails++; $display("FAIL rr_share got %0d/%0d exp 4/4", done[0], done[1]); end
        for (int i = 0; i < 3; i++) next_cycle();
    endtask

    task automatic test_stall();
        mode = 1'b0;
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h20;
        #1;
        tests++; if (s_haddr !== 32'h20) begin fails++; $display("FAIL stall_a_addr got %h exp 20", s_haddr); end
        next_cycle();
        idle_masters();
        M1_HTRANS = 2'b10; M1_HADDR = 32'h1004;
        S_HREADYOUT = 1'b0;
        #1;
        // M1 has nothing parked yet, so its HREADY is still high here and the beat is captured.
        tests++; if (s_hready !== 1'b0 || s_htrans !== 2'b00) begin fails++; $display("FAIL stall_b_bus got %0b/%0h exp 0/0", s_hready, s_htrans); end
        tests++; if (m1_hready !== 1'b1 || m0_hready !== 1'b0) begin fails++; $display("FAIL stall_b_ready got %b exp 10", {m1_hready, m0_hready}); end
        next_cycle();
        idle_masters();
        #1;
        tests++; if (s_htrans !== 2'b00 || m1_hready !== 1'b0) begin fails++; $display("FAIL stall_c got %0h/%0b exp 0/0", s_htrans, m1_hready); end
        next_cycle();
        S_HREADYOUT = 1'b1;
        #1;
        tests++; if (s_htrans !== 2'b10 || s_haddr !== 32'h1004) begin fails++; $display("FAIL stall_d_fwd got %0h/%h exp 2/1004", s_htrans, s_haddr); end
        tests++; if (m1_hready !== 1'b0) begin fails++; $display("FAIL stall_d_m1 got %0b exp 0", m1_hready); end
        tests++; if (m0_hready !== 1'b1 || m0_hrdata !== 32'hC0DE_0008) begin fails++; $display("FAIL stall_d_m0 got %0b/%h exp 1/c0de0008", m0_hready, m0_hrdata); end
        next_cycle();
        #1;
        tests++; if (m1_hready !== 1'b1 || m1_hrdata !== 32'hC0DE_0401) begin fails++; $display("FAIL stall_e_m1 got %0b/%h exp 1/c0de0401", m1_hready, m1_hrdata); end
        next_cycle();
    endtask

    task automatic test_reset_pending();
        mode = 1'b0;
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h30;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h1008;
        #1;
        next_cycle();
        idle_masters();
        HRESETn = 1'b0;
        #1;
        tests++; if (m1_hready !== 1'b1 || m0_hready !== 1'b1) begin fails++; $display("FAIL rstp_hready got %b exp 11", {m0_hready, m1_hready}); end
        tests++; if (s_htrans !== 2'b00 || s_hready !== 1'b1) begin fails++; $display("FAIL rstp_bus got %0h/%0b exp 0/1", s_htrans, s_hready); end
        next_cycle();
        next_cycle();
        HRESETn = 1'b1;
        sl_dp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (s_htrans !== 2'b00 || m1_hready !== 1'b1) begin fails++; $display("FAIL rstp_noreplay c%0d got %0h/%0b exp 0/1", i, s_htrans, m1_hready); end
            next_cycle();
        end
    endtask

    // Random traffic: each master issues unique addresses; the slave must see
    // every accepted beat exactly once, in per-master order, with right data.
    task automatic test_random(input logic m, input int ncyc);
        logic        a_v [2], a_w [2], d_v [2], d_w [2], hr [2];
        logic [31:0] a_addr [2], d_addr [2], rdat [2];
        logic [32:0] q0 [$];
        logic [32:0] q1 [$];
        logic [32:0] head;
        int          k [2];
        int          x;
        int          cyc;
        mode = m;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            a_v[i] = 1'b0; d_v[i] = 1'b0; a_w[i] = 1'b0; d_w[i] = 1'b0;
            a_addr[i] = '0; d_addr[i] = '0; k[i] = 0;
        end
        cyc = 0;
        while (cyc < ncyc + 80) begin
            if (cyc >= ncyc && !a_v[0] && !a_v[1] && !d_v[0] && !d_v[1]
                && q0.size() == 0 && q1.size() == 0 && !sl_dp_valid) break;
            for (int i = 0; i < 2; i++) begin
                if (!a_v[i] && cyc < ncyc && $urandom_range(0, 2) != 0) begin
                    a_v[i] = 1'b1;
                    a_w[i] = 1'($urandom_range(0, 1));
                    a_addr[i] = (32'(i) << 12) | (32'(k[i] % 1024) << 2);
                    k[i]++;
                end
            end
            M0_HTRANS = a_v[0] ? 2'b10 : 2'b00; M0_HADDR = a_addr[0]; M0_HWRITE = a_w[0];
            M1_HTRANS = a_v[1] ? 2'b11 : 2'b00; M1_HADDR = a_addr[1]; M1_HWRITE = a_w[1];
            M0_HWDATA = d_v[0] ? wd(d_addr[0]) : $urandom();
            M1_HWDATA = d_v[1] ? wd(d_addr[1]) : $urandom();
            S_HREADYOUT = ($urandom_range(0, 3) != 0);
            #1;
            hr[0] = m0_hready; hr[1] = m1_hready;
            rdat[0] = m0_hrdata; rdat[1] = m1_hrdata;
            for (int i = 0; i < 2; i++) begin
                if (hr[i]) begin
                    if (d_v[i] && !d_w[i]) begin
                        tests++;
                        if (rdat[i] !== rom(d_addr[i])) begin fails++; $display("FAIL rnd_rdata M%0d a=%h got %h exp %h", i, d_addr[i], rdat[i], rom(d_addr[i])); end
                    end
                    d_v[i] = a_v[i]; d_w[i] = a_w[i]; d_addr[i] = a_addr[i];
                    if (a_v[i]) begin
                        if (i == 0) q0.push_back({a_w[i], a_addr[i]});
                        else q1.push_back({a_w[i], a_addr[i]});
                    end
                    a_v[i] = 1'b0;
                end
            end
            if (sl_dp_valid && sl_dp_write && S_HREADYOUT) begin
                tests++;
                if (s_hwdata !== wd(sl_dp_addr)) begin fails++; $display("FAIL rnd_wdata a=%h got %h exp %h", sl_dp_addr, s_hwdata, wd(sl_dp_addr)); end
            end
            if (s_hready && s_htrans[1]) begin
                x = int'(s_haddr[12]);
                head = 33'h1_FFFF_FFFF;
                if (x == 0 && q0.size() > 0) head = q0.pop_front();
                if (x == 1 && q1.size() > 0) head = q1.pop_front();
                tests++;
                if ({s_hwrite, s_haddr} !== head) begin fails++; $display("FAIL rnd_order M%0d got %h exp %h", x, {s_hwrite, s_haddr}, head); end
            end
            next_cycle();
            cyc++;
        end
        tests++;
        if (a_v[0] || a_v[1] || d_v[0] || d_v[1] || q0.size() != 0 || q1.size() != 0) begin
            fails++; $display("FAIL rnd_drain mode%0d got q=%0d/%0d exp 0/0 outstanding", m, q0.size(), q1.size());
        end
        idle_masters();
        S_HREADYOUT = 1'b1;
        next_cycle();
    endtask

    initial begin
        idle_masters();
        S_HREADYOUT = 1'b1;
        S_HRDATA = 32'hDEAD_BEEF;
        @(negedge HCLK);
        test_reset();
        test_single_read();
        test_fixed_prio();
        test_round_robin();
        test_stall();
        test_reset_pending();
        test_random(1'b0, 400);
        test_random(1'b1, 400);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
